// File: rtl/core_pkg.sv
// Shared encodings, FSM states and ALU operations for the multi-cycle RV32I-subset core.
package core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_B, IMM_U, IMM_J} imm_type_t;

  typedef enum logic [1:0] {CLS_ALU, CLS_BRANCH, CLS_JAL} op_class_t;

  // 32-bit immediate; callers sign-extend to XLEN.
  function automatic logic [31:0] build_imm(input logic [31:0] ir, input imm_type_t t);
    logic [31:0] imm;
    imm = '0;
    case (t)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   imm = {ir[31:12], 12'b0};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational integer ALU; shifts use the low $clog2(XLEN) bits of b.
module core_alu
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_t         op_i,
  output logic [XLEN-1:0] y_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_SLL:   y_o = a_i << shamt;
      ALU_SLT:   y_o = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU:  y_o = XLEN'(a_i < b_i);
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_SRL:   y_o = a_i >> shamt;
      ALU_SRA:   y_o = XLEN'($signed(a_i) >>> shamt);
      ALU_OR:    y_o = a_i | b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_PASSB: y_o = b_i;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK core with valid/ready fetch, halt-on-error and retire pulse.
module multicycle_core
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter bit              ERR_HALT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     komut,
  input  logic            komut_valid,
  output logic            komut_ready,
  output logic [XLEN-1:0] pc,
  output logic            hata,
  output logic            durdu,
  output logic            retire
);

  localparam int IDXW = $clog2(NREG);

  state_t          state_q, state_d;
  logic            started_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rf_q [NREG];
  logic            hata_q, retire_q;

  alu_op_t         op_q;
  op_class_t       cls_q;
  logic [2:0]      f3_q;
  logic            we_q, err_q;
  logic [IDXW-1:0] rd_q;
  logic [XLEN-1:0] a_q, b_q, imm_q;

  logic [XLEN-1:0] res_q, npc_q;
  logic            wb_we_q;

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 != 5'd0 && int'(rs1) < NREG) ? rf_q[rs1[IDXW-1:0]] : '0;
  assign rs2_val = (rs2 != 5'd0 && int'(rs2) < NREG) ? rf_q[rs2[IDXW-1:0]] : '0;

  // Shift-immediate upper field: RV64 steals ir[25] as shamt[5].
  logic [6:0] shf_hi, sra_tag;
  assign shf_hi  = (XLEN == 64) ? {1'b0, ir_q[31:26]} : ir_q[31:25];
  assign sra_tag = (XLEN == 64) ? 7'b0010000 : 7'b0100000;

  alu_op_t   dec_op;
  op_class_t dec_cls;
  imm_type_t dec_imm_t;
  logic      dec_we, dec_use_imm, use_rs1, use_rs2, use_rd, dec_illegal;

  always_comb begin
    dec_op = ALU_ADD; dec_cls = CLS_ALU; dec_imm_t = IMM_NONE;
    dec_we = 1'b0; dec_use_imm = 1'b0; dec_illegal = 1'b0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    case (opc)
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; dec_we = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: dec_op = ALU_ADD;
            3'b001: dec_op = ALU_SLL;
            3'b010: dec_op = ALU_SLT;
            3'b011: dec_op = ALU_SLTU;
            3'b100: dec_op = ALU_XOR;
            3'b101: dec_op = ALU_SRL;
            3'b110: dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) dec_op = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) dec_op = ALU_SRA;
        else dec_illegal = 1'b1;
      end
      OPC_OPIMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1; dec_we = 1'b1;
        dec_use_imm = 1'b1; dec_imm_t = IMM_I;
        case (f3)
          3'b000: dec_op = ALU_ADD;
          3'b010: dec_op = ALU_SLT;
          3'b011: dec_op = ALU_SLTU;
          3'b100: dec_op = ALU_XOR;
          3'b110: dec_op = ALU_OR;
          3'b111: dec_op = ALU_AND;
          3'b001: begin
            dec_op = ALU_SLL;
            dec_illegal = (shf_hi != 7'd0);
          end
          default: begin
            if (shf_hi == 7'd0) dec_op = ALU_SRL;
            else if (shf_hi == sra_tag) dec_op = ALU_SRA;
            else dec_illegal = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        use_rd = 1'b1; dec_we = 1'b1; dec_use_imm = 1'b1;
        dec_imm_t = IMM_U; dec_op = ALU_PASSB;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec_cls = CLS_BRANCH; dec_imm_t = IMM_B;
        dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        use_rd = 1'b1; dec_we = 1'b1; dec_cls = CLS_JAL; dec_imm_t = IMM_J;
      end
      default: dec_illegal = 1'b1;
    endcase
    if ((use_rs1 && int'(rs1) >= NREG) || (use_rs2 && int'(rs2) >= NREG) ||
        (use_rd && int'(rd) >= NREG))
      dec_illegal = 1'b1;
  end

  logic [XLEN-1:0] dec_imm;
  assign dec_imm = XLEN'($signed(build_imm(ir_q, dec_imm_t)));

  logic [XLEN-1:0] alu_y;
  core_alu #(.XLEN(XLEN)) u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  logic            br_cond, taken, exec_err;
  logic [XLEN-1:0] pc_plus4, target;
  always_comb begin
    case (f3_q)
      3'b000:  br_cond = (a_q == b_q);
      3'b001:  br_cond = (a_q != b_q);
      3'b100:  br_cond = ($signed(a_q) < $signed(b_q));
      3'b101:  br_cond = ($signed(a_q) >= $signed(b_q));
      3'b110:  br_cond = (a_q < b_q);
      3'b111:  br_cond = (a_q >= b_q);
      default: br_cond = 1'b0;
    endcase
    taken    = (cls_q == CLS_JAL) || (cls_q == CLS_BRANCH && br_cond);
    pc_plus4 = pc_q + XLEN'(4);
    target   = pc_q + imm_q;
    exec_err = err_q || (taken && target[1:0] != 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    komut_ready = 1'b0;
    durdu       = 1'b0;
    case (state_q)
      FETCH: begin
        komut_ready = started_q;
        if (komut_valid && started_q) state_d = DECODE;
      end
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = (exec_err && ERR_HALT) ? HALT : WRITEBACK;
      WRITEBACK: state_d = FETCH;
      HALT:      durdu = 1'b1;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q <= '0; pc_q <= PC_RESET; hata_q <= 1'b0; retire_q <= 1'b0;
      op_q <= ALU_ADD; cls_q <= CLS_ALU; f3_q <= '0; we_q <= 1'b0; err_q <= 1'b0;
      rd_q <= '0; a_q <= '0; b_q <= '0; imm_q <= '0;
      res_q <= '0; npc_q <= '0; wb_we_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        FETCH: if (komut_valid && komut_ready) ir_q <= komut;
        DECODE: begin
          op_q  <= dec_op;
          cls_q <= dec_cls;
          f3_q  <= f3;
          we_q  <= dec_we && (rd != 5'd0);
          err_q <= dec_illegal;
          rd_q  <= rd[IDXW-1:0];
          a_q   <= rs1_val;
          b_q   <= dec_use_imm ? dec_imm : rs2_val;
          imm_q <= dec_imm;
        end
        EXECUTE: begin
          res_q   <= (cls_q == CLS_JAL) ? pc_plus4 : alu_y;
          npc_q   <= (taken && !exec_err) ? target : pc_plus4;
          wb_we_q <= we_q && !exec_err;
          if (exec_err) hata_q <= 1'b1;
        end
        WRITEBACK: begin
          if (wb_we_q) rf_q[rd_q] <= res_q;
          pc_q     <= npc_q;
          retire_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc     = pc_q;
  assign hata   = hata_q;
  assign retire = retire_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: one halting instance and one NOP-on-error instance.
module tb_multicycle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, komut_valid, komut_ready, hata, durdu, retire;
  logic [31:0] komut, pc;
  logic        rst_n2, valid2, ready2, hata2, durdu2, retire2;
  logic [31:0] komut2, pc2;

  multicycle_core #(.XLEN(32), .NREG(32), .PC_RESET(32'h0), .ERR_HALT(1'b1)) dut (
    .clk(clk), .reset(rst_n), .komut(komut), .komut_valid(komut_valid),
    .komut_ready(komut_ready), .pc(pc), .hata(hata), .durdu(durdu), .retire(retire)
  );

  multicycle_core #(.XLEN(32), .NREG(32), .PC_RESET(32'h0), .ERR_HALT(1'b0)) dut_nop (
    .clk(clk), .reset(rst_n2), .komut(komut2), .komut_valid(valid2),
    .komut_ready(ready2), .pc(pc2), .hata(hata2), .durdu(durdu2), .retire(retire2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rst_n2 = 1'b0; komut_valid = 1'b0; valid2 = 1'b0;
    step(); step();
    rst_n = 1'b1; rst_n2 = 1'b1;
    step();
  endtask

  task automatic issue(input logic [31:0] instr);
    int n;
    komut = instr; komut_valid = 1'b1; n = 0;
    while (!komut_ready && n < 20) begin step(); n++; end
    if (!komut_ready) check_eq("handshake_timeout", komut_ready, 1);
    step();
    komut_valid = 1'b0;
    komut = 32'hDEAD_BEEF;
  endtask

  task automatic exec(input logic [31:0] instr, input string tag);
    int lat;
    logic [31:0] p;
    p = pc; lat = 0;
    issue(instr);
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      step();
      if (retire) lat = i;
    end
    $display("txn %s pc=0x%08h instr=0x%08h retire_edges=%0d new_pc=0x%08h", tag, p, instr, lat, pc);
    check_eq({tag, "_lat"}, lat, 3);
  endtask

  task automatic setup_branch();
    do_reset();
    exec(32'h00300093, "addi_x1_3");
    exec(32'h00300113, "addi_x2_3");
    exec(32'h00000013, "nop");
    exec(32'h00000013, "nop");
  endtask

  initial begin
    int cnt, lat;
    rst_n = 1'b0; rst_n2 = 1'b0; komut = '0; komut2 = '0; komut_valid = 1'b0; valid2 = 1'b0;
    step(); step();
    check_eq("rst_pc", pc, 0);
    check_eq("rst_hata", hata, 0);
    check_eq("rst_durdu", durdu, 0);
    check_eq("rst_retire", retire, 0);
    check_eq("rst_ready", komut_ready, 0);
    rst_n = 1'b1; rst_n2 = 1'b1;
    #1 check_eq("ready_before_edge", komut_ready, 0);
    step();
    check_eq("ready_after_edge", komut_ready, 1);

    // Test 1
    exec(32'h00500093, "addi_x1_5");
    check_eq("t1_x1", dut.rf_q[1], 5);
    check_eq("t1_pc", pc, 32'h4);
    step();
    check_eq("t1_retire_one_cycle", retire, 0);

    // Test 2: shifts, plus SUB/SLT/SLTU on the results
    exec(32'hFFF00093, "addi_x1_m1");
    exec(32'h4040D113, "srai_x2");
    exec(32'h01C0D193, "srli_x3");
    check_eq("t2_x2", dut.rf_q[2], 32'hFFFF_FFFF);
    check_eq("t2_x3", dut.rf_q[3], 32'hF);
    exec(32'h40218233, "sub_x4");
    exec(32'h0000A2B3, "slt_x5");
    exec(32'h00103333, "sltu_x6");
    check_eq("t2_x4", dut.rf_q[4], 32'h10);
    check_eq("t2_x5", dut.rf_q[5], 1);
    check_eq("t2_x6", dut.rf_q[6], 1);
    check_eq("t2_pc", pc, 32'h1C);

    // Test 3
    setup_branch();
    check_eq("t3_pc_pre", pc, 32'h10);
    exec(32'h00208463, "beq_taken");
    check_eq("t3_beq_pc", pc, 32'h18);
    setup_branch();
    exec(32'h00209463, "bne_not_taken");
    check_eq("t3_bne_pc", pc, 32'h14);

    // Test 4
    do_reset();
    for (int i = 0; i < 16; i++) exec(32'h00000013, "nop");
    exec(32'h020000EF, "jal_x1_20");
    check_eq("t4_x1", dut.rf_q[1], 32'h44);
    check_eq("t4_pc", pc, 32'h60);
    do_reset();
    for (int i = 0; i < 16; i++) exec(32'h00000013, "nop");
    issue(32'h002000EF);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin step(); if (retire) cnt++; end
    $display("txn jal_misaligned pc=0x%08h hata=%0b durdu=%0b retires=%0d", pc, hata, durdu, cnt);
    check_eq("t4_err_retire", cnt, 0);
    check_eq("t4_err_hata", hata, 1);
    check_eq("t4_err_durdu", durdu, 1);
    check_eq("t4_err_pc", pc, 32'h40);
    check_eq("t4_err_x1", dut.rf_q[1], 0);

    // Test 5: illegal load opcode, halting instance
    do_reset();
    issue(32'h00002283);
    cnt = 0;
    komut = 32'h00500093; komut_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin step(); if (retire) cnt++; end
    komut_valid = 1'b0;
    $display("txn load_halt pc=0x%08h hata=%0b durdu=%0b retires=%0d", pc, hata, durdu, cnt);
    check_eq("t5_halt_retire", cnt, 0);
    check_eq("t5_halt_hata", hata, 1);
    check_eq("t5_halt_durdu", durdu, 1);
    check_eq("t5_halt_ready", komut_ready, 0);
    check_eq("t5_halt_pc", pc, 0);

    // Test 5: illegal load opcode, NOP-on-error instance
    do_reset();
    komut2 = 32'h00002283; valid2 = 1'b1;
    step();
    valid2 = 1'b0; lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin step(); if (retire2) lat = i; end
    $display("txn load_nop pc=0x%08h hata=%0b retire_edges=%0d", pc2, hata2, lat);
    check_eq("t5_nop_lat", lat, 3);
    check_eq("t5_nop_hata", hata2, 1);
    check_eq("t5_nop_pc", pc2, 32'h4);
    check_eq("t5_nop_durdu", durdu2, 0);
    komut2 = 32'h00500093; valid2 = 1'b1;
    step();
    valid2 = 1'b0; lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin step(); if (retire2) lat = i; end
    $display("txn addi_after_err pc=0x%08h retire_edges=%0d", pc2, lat);
    check_eq("t5_nop_addi_lat", lat, 3);
    check_eq("t5_nop_x1", dut_nop.rf_q[1], 5);
    check_eq("t5_nop_pc2", pc2, 32'h8);
    check_eq("t5_nop_hata_sticky", hata2, 1);

    // Test 6: idle fetch, reset in EXECUTE, write to x0
    do_reset();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      komut = 32'h00100093 + 32'(i);
      step();
      if (retire) cnt++;
    end
    check_eq("t6_idle_retire", cnt, 0);
    check_eq("t6_idle_pc", pc, 0);
    check_eq("t6_idle_ready", komut_ready, 1);
    issue(32'h00900293);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_pc", pc, 0);
    check_eq("t6_rst_ready", komut_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    $display("txn reset_in_execute pc=0x%08h x5=0x%08h", pc, dut.rf_q[5]);
    check_eq("t6_x5", dut.rf_q[5], 0);
    check_eq("t6_ready_fetch", komut_ready, 1);
    check_eq("t6_no_retire", retire, 0);
    exec(32'h00700013, "addi_x0_7");
    check_eq("t6_x0", dut.rf_q[0], 0);
    check_eq("t6_hata", hata, 0);
    check_eq("t6_pc", pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
